// File: rtl/writeback_unit.sv
// Writeback stage: formats load returns into a small FIFO and arbitrates them
// with ALU results onto the register-file write port. Optional pending-load
// scoreboard on o_busy is built when WRITEBACK_SCOREBOARD_EN is defined.
module writeback_unit #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,

    input  logic                          i_alu_valid,
    input  logic [4:0]                    i_alu_rd_num,
    input  logic [31:0]                   i_alu_val,
    output logic                          o_alu_ready,

    input  logic                          i_ld_issue,
    input  logic [4:0]                    i_ld_issue_rd_num,

    input  logic                          i_mem_valid,
    input  logic [4:0]                    i_mem_rd_num,
    input  logic [31:0]                   i_mem_val,
    input  logic [2:0]                    i_mem_func_3,
    input  logic [1:0]                    i_mem_addr_lo,
    output logic                          o_mem_ready,

    output logic                          o_reg_op,
    output logic [31:0]                   o_w_rd,
    output logic [4:0]                    o_w_rd_num,
    output logic [31:0]                   o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // ------------------------------------------------------------------
    // Load formatting
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    always_comb begin
        case (i_mem_addr_lo)
            2'd0:    ld_byte = i_mem_val[7:0];
            2'd1:    ld_byte = i_mem_val[15:8];
            2'd2:    ld_byte = i_mem_val[23:16];
            default: ld_byte = i_mem_val[31:24];
        endcase
        ld_half = i_mem_addr_lo[1] ? i_mem_val[31:16] : i_mem_val[15:0];

        case (i_mem_func_3)
            F3_LB:   ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_fmt = {24'h000000, ld_byte};
            F3_LH:   ld_fmt = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_fmt = {16'h0000, ld_half};
            default: ld_fmt = i_mem_val;
        endcase
    end

    // ------------------------------------------------------------------
    // Load-return FIFO
    // ------------------------------------------------------------------
    logic [4:0]    fifo_rd_q  [FIFO_DEPTH];
    logic [31:0]   fifo_val_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          alu_take;
    logic [4:0]    head_rd;
    logic [31:0]   head_val;

    // Readiness comes from the registered count only, so a full FIFO never
    // accepts even when the same cycle pops.
    assign fifo_empty  = (count_q == '0);
    assign o_mem_ready = (count_q < DEPTH_C);
    assign o_alu_ready = fifo_empty;
    assign push        = i_mem_valid & o_mem_ready;
    assign pop         = ~fifo_empty;
    assign alu_take    = fifo_empty & i_alu_valid;
    assign head_rd     = fifo_rd_q[rd_ptr_q];
    assign head_val    = fifo_val_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]  <= i_mem_rd_num;
            fifo_val_q[wr_ptr_q] <= ld_fmt;
        end
    end

    // ------------------------------------------------------------------
    // Write-port arbitration: FIFO head has priority over the ALU
    // ------------------------------------------------------------------
    logic        reg_op_q, reg_op_d;
    logic [31:0] w_rd_q, w_rd_d;
    logic [4:0]  w_rd_num_q, w_rd_num_d;

    always_comb begin
        reg_op_d   = 1'b0;
        w_rd_d     = w_rd_q;
        w_rd_num_d = w_rd_num_q;
        if (pop) begin
            reg_op_d   = (head_rd != '0);
            w_rd_d     = head_val;
            w_rd_num_d = head_rd;
        end else if (alu_take) begin
            reg_op_d   = (i_alu_rd_num != '0);
            w_rd_d     = i_alu_val;
            w_rd_num_d = i_alu_rd_num;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            reg_op_q   <= 1'b0;
            w_rd_q     <= '0;
            w_rd_num_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            reg_op_q   <= reg_op_d;
            w_rd_q     <= w_rd_d;
            w_rd_num_q <= w_rd_num_d;
        end
    end

    assign o_reg_op     = reg_op_q;
    assign o_w_rd       = w_rd_q;
    assign o_w_rd_num   = w_rd_num_q;
    assign o_fifo_count = count_q;

    // ------------------------------------------------------------------
    // Pending-load scoreboard
    // ------------------------------------------------------------------
`ifdef WRITEBACK_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Clear is applied before set so a same-cycle reissue keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (i_ld_issue && (i_ld_issue_rd_num != '0)) begin
            busy_d[i_ld_issue_rd_num] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;
`else
    logic unused_ld_issue;
    assign unused_ld_issue = ^{i_ld_issue, i_ld_issue_rd_num};
    assign o_busy          = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed + random bench for writeback_unit: expected writes are queued at
// stimulus time from a behavioural model and checked when o_reg_op fires.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_val;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_val;
    logic [2:0]  mem_f3;
    logic [1:0]  mem_lo;
    logic        mem_ready;
    logic        reg_op;
    logic [31:0] w_rd;
    logic [4:0]  w_rd_num;
    logic [31:0] busy;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    writeback_unit #(.FIFO_DEPTH(4)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_alu_valid       (alu_valid),
        .i_alu_rd_num      (alu_rd),
        .i_alu_val         (alu_val),
        .o_alu_ready       (alu_ready),
        .i_ld_issue        (ld_issue),
        .i_ld_issue_rd_num (ld_issue_rd),
        .i_mem_valid       (mem_valid),
        .i_mem_rd_num      (mem_rd),
        .i_mem_val         (mem_val),
        .i_mem_func_3      (mem_f3),
        .i_mem_addr_lo     (mem_lo),
        .o_mem_ready       (mem_ready),
        .o_reg_op          (reg_op),
        .o_w_rd            (w_rd),
        .o_w_rd_num        (w_rd_num),
        .o_busy            (busy),
        .o_fifo_count      (fifo_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;

    wr_t         mq[$];
    wr_t         expq[$];
    logic [31:0] mbusy;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = w >> (8 * lo);
        sh = w >> (16 * lo[1]);
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb[7:0]};
            3'b100:  return {24'h0, sb[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // One clock: check pre-edge readiness, advance the model, check post-edge outputs.
    task automatic cycle(input logic [31:0] ld_exp);
        int  sz;
        wr_t e;
        wr_t got;
        bit  w;
        sz = mq.size();
        w  = 1'b0;
        if (!rst) begin
            chk("mem_ready", {31'b0, mem_ready}, (sz < 4) ? 32'd1 : 32'd0);
            chk("alu_ready", {31'b0, alu_ready}, (sz == 0) ? 32'd1 : 32'd0);
            chk("fifo_count", {29'b0, fifo_count}, sz);
        end
        if (rst) begin
            mq.delete();
            expq.delete();
            mbusy = '0;
        end else begin
            if (sz > 0) begin
                e = mq.pop_front();
                mbusy[e.rd] = 1'b0;
                if (e.rd != 5'd0) begin
                    expq.push_back(e);
                    w = 1'b1;
                end
            end else if (alu_valid && alu_rd != 5'd0) begin
                expq.push_back('{alu_rd, alu_val});
                w = 1'b1;
            end
            if (mem_valid && sz < 4) begin
                mq.push_back('{mem_rd, ld_exp});
            end
`ifdef WRITEBACK_SCOREBOARD_EN
            if (ld_issue && ld_issue_rd != 5'd0) begin
                mbusy[ld_issue_rd] = 1'b1;
            end
`endif
        end
        @(posedge clk);
        #1;
        chk("reg_op", {31'b0, reg_op}, {31'b0, w});
        if (reg_op === 1'b1 && expq.size() > 0) begin
            got = expq.pop_front();
            chk("w_rd_num", {27'b0, w_rd_num}, {27'b0, got.rd});
            chk("w_rd", w_rd, got.val);
        end
        chk("busy", busy, mbusy);
        if (rst) begin
            chk("rst_w_rd", w_rd, 32'h0);
            chk("rst_w_rd_num", {27'b0, w_rd_num}, 32'h0);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mval,
                         input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] lexp,
                         input logic iss, input logic [4:0] ird);
        alu_valid   = av;
        alu_rd      = ard;
        alu_val     = aval;
        mem_valid   = mv;
        mem_rd      = mrd;
        mem_val     = mval;
        mem_f3      = f3;
        mem_lo      = lo;
        ld_issue    = iss;
        ld_issue_rd = ird;
        cycle(lexp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    localparam logic [31:0] W = 32'h80FF7F01;

    initial begin
        mbusy = '0;
        rst   = 1'b1;
        idle(2);
        rst   = 1'b0;

        // ALU only, then a write to x0
        drive(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // load formatting against fixed expectations
        drive(0, 0, 0, 1, 1, W, 3'b000, 2'd3, 32'hFFFFFF80, 0, 0);
        drive(0, 0, 0, 1, 2, W, 3'b100, 2'd1, 32'h0000007F, 0, 0);
        drive(0, 0, 0, 1, 3, W, 3'b001, 2'd2, 32'hFFFF80FF, 0, 0);
        drive(0, 0, 0, 1, 4, W, 3'b101, 2'd0, 32'h00007F01, 0, 0);
        drive(0, 0, 0, 1, 6, W, 3'b010, 2'd0, W, 0, 0);
        idle(2);

        // collision: ALU wins on empty FIFO, load drains next, ALU stalls meanwhile
        drive(1, 9, 32'hAAAA, 1, 10, W, 3'b010, 2'd0, W, 0, 0);
        drive(1, 11, 32'hBBBB, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 11, 32'hBBBB, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // five back-to-back returns with ALU continuously offered
        for (int i = 0; i < 5; i++) begin
            drive(1, 12, 32'h100 + i, 1, 5'(13 + i), 32'hC0DE0000 + i, 3'b010, 2'd0,
                  32'hC0DE0000 + i, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 12, 32'h200 + i, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        idle(2);

        // scoreboard: issue, return, reissue on the writeback cycle
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        idle(1);
        drive(0, 0, 0, 1, 7, W, 3'b010, 2'd0, W, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        idle(1);
        drive(0, 0, 0, 1, 7, 32'h55, 3'b010, 2'd0, 32'h55, 1, 0);
        drive(0, 0, 0, 1, 0, 32'h66, 3'b010, 2'd0, 32'h66, 0, 0);
        idle(2);

        // reset mid-operation with an entry queued and busy bits set
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
        drive(1, 20, 32'h77, 1, 3, 32'h99, 3'b010, 2'd0, 32'h99, 1, 4);
        rst = 1'b1;
        drive(1, 21, 32'h88, 1, 8, 32'hAB, 3'b010, 2'd0, 32'hAB, 0, 0);
        rst = 1'b0;
        idle(3);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  f3;
            logic [1:0]  lo;
            logic [31:0] mv;
            f3 = 3'($urandom);
            lo = 2'($urandom);
            mv = $urandom;
            drive(1'($urandom), 5'($urandom), $urandom,
                  1'($urandom), 5'($urandom), mv, f3, lo, fmt(f3, lo, mv),
                  1'($urandom), 5'($urandom));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
